// File: rtl/mod_74xx_pkg.sv
// Shared constants and types for the 74xx discrete-logic leaf cells.
package mod_74xx_pkg;

    localparam int unsigned N_GATES_74X04_2 = 2;

    typedef logic [1:0] gate_vec_t;

    // Registered output value under reset: the inverse of an all-zero input.
    localparam gate_vec_t Y_RST_74X04 = 2'b11;

endpackage

// File: rtl/mod_74x04_2_if.sv
// Bundle of the inverter slice data pins (gate inputs and gate outputs).
interface mod_74x04_2_if;
    import mod_74xx_pkg::*;

    gate_vec_t A;
    gate_vec_t Y;

    modport master (output A, input Y);
    modport slave  (input A, output Y);

endinterface

// File: rtl/mod_74x04_2_split.sv
// Two-channel 74x04 inverter slice, split view of two explicit gates; MOD_74X04_2_REG_EN adds output flops.
module mod_74x04_2_split
    import mod_74xx_pkg::*;
#(
    parameter int unsigned N_GATES = N_GATES_74X04_2
) (
    input  logic [N_GATES-1:0] A,
    output logic [N_GATES-1:0] Y,
    input  logic               clk,
    input  logic               rst_n
);

    // Pins 1A/1Y.
    mod_74x04_gate u_gate_1 (
        .a     (A[0]),
        .y     (Y[0]),
        .clk   (clk),
        .rst_n (rst_n)
    );

    // Pins 2A/2Y.
    mod_74x04_gate u_gate_2 (
        .a     (A[1]),
        .y     (Y[1]),
        .clk   (clk),
        .rst_n (rst_n)
    );

endmodule

// File: rtl/mod_74x04_gate.sv
// Single inverter gate of a 74x04; output register enabled by MOD_74X04_2_REG_EN.
module mod_74x04_gate (
    input  logic a,
    output logic y,
    input  logic clk,
    input  logic rst_n
);

`ifdef MOD_74X04_2_REG_EN
    // One flop per channel, reset to the complement of a zero input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y <= 1'b1;
        end else begin
            y <= ~a;
        end
    end
`else
    // Zero-delay inverter; clock and reset are deliberately left unused.
    logic w_unused_clk_rst;
    assign w_unused_clk_rst = clk ^ rst_n;

    assign y = ~a;
`endif

endmodule

// File: rtl/mod_74x04_2.sv
// Two-channel 74x04 inverter slice, vector view; registered outputs with MOD_74X04_2_REG_EN.
module mod_74x04_2
    import mod_74xx_pkg::*;
#(
    parameter int unsigned N_GATES = N_GATES_74X04_2
) (
    input  logic [N_GATES-1:0] A,
    output logic [N_GATES-1:0] Y,
    input  logic               clk,
    input  logic               rst_n
);

    for (genvar g = 0; g < N_GATES; g++) begin : g_gate
        mod_74x04_gate u_gate (
            .a     (A[g]),
            .y     (Y[g]),
            .clk   (clk),
            .rst_n (rst_n)
        );
    end

endmodule

// File: tb/tb_mod_74x04_2.sv
// Self-checking bench for both views of the 74x04 two-channel inverter slice.
module tb_mod_74x04_2;
    import mod_74xx_pkg::*;

    logic clk = 1'b0;
    logic rst_n;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    mod_74x04_2_if bus_v ();
    mod_74x04_2_if bus_s ();

    mod_74x04_2 #(.N_GATES(N_GATES_74X04_2)) u_vec (
        .A     (bus_v.A),
        .Y     (bus_v.Y),
        .clk   (clk),
        .rst_n (rst_n)
    );

    mod_74x04_2_split #(.N_GATES(N_GATES_74X04_2)) u_split (
        .A     (bus_s.A),
        .Y     (bus_s.Y),
        .clk   (clk),
        .rst_n (rst_n)
    );

    always #5 clk = ~clk;

    // Reference: known inputs map to 3 - A; unknown bits follow the per-channel truth table.
    function automatic gate_vec_t ref_inv(input gate_vec_t a);
        gate_vec_t r;
        if (!$isunknown(a)) begin
            r = gate_vec_t'(3 - int'(a));
        end else begin
            for (int i = 0; i < 2; i++) begin
                case (a[i])
                    1'b0:    r[i] = 1'b1;
                    1'b1:    r[i] = 1'b0;
                    default: r[i] = 1'bx;
                endcase
            end
        end
        return r;
    endfunction

    task automatic drive(input gate_vec_t a);
        bus_v.A = a;
        bus_s.A = a;
    endtask

    task automatic check(input string tag, input gate_vec_t obs, input gate_vec_t exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_both(input string tag, input gate_vec_t exp);
        check({tag, "_vec"},   bus_v.Y, exp);
        check({tag, "_split"}, bus_s.Y, exp);
    endtask

    initial begin
        gate_vec_t a;
        gate_vec_t ax;
        gate_vec_t exp_y;
        logic      rst_bit;

        rst_n = 1'b0;
        ax    = 2'b1x;

`ifdef MOD_74X04_2_REG_EN
        // Reset forces 11 before any clock edge has occurred.
        drive(2'b11);
        #1;
        check_both("rst_async", Y_RST_74X04);

        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_both("first_edge", 2'b00);

        @(negedge clk);
        drive(2'b00);
        @(posedge clk);
        #1;
        check_both("capture_00", 2'b11);

        @(negedge clk);
        drive(2'b10);
        #1;
        check_both("hold_before_edge", 2'b11);
        @(posedge clk);
        #1;
        check_both("capture_10", 2'b01);

        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_both("rst_mid_cycle", 2'b11);

        @(negedge clk);
        rst_n = 1'b1;
        drive(ax);
        @(posedge clk);
        #1;
        check_both("x_prop", ref_inv(ax));

        // Random inputs with occasional reset pulses against a one-cycle model.
        @(negedge clk);
        exp_y = ref_inv(ax);
        for (int i = 0; i < 40; i++) begin
            check_both("rand_pipe", exp_y);
            a       = gate_vec_t'($urandom);
            rst_bit = ($urandom_range(0, 7) != 0);
            drive(a);
            rst_n = rst_bit;
            if (!rst_bit) begin
                #1;
                check_both("rand_rst_async", Y_RST_74X04);
            end
            @(posedge clk);
            exp_y = rst_bit ? ref_inv(a) : Y_RST_74X04;
            @(negedge clk);
        end
        check_both("rand_pipe_last", exp_y);
`else
        // Clock and reset have no effect: output tracks input while reset is low.
        drive(2'b00);
        #1;
        check_both("rst_ignored", 2'b11);
        rst_n = 1'b1;

        drive(2'b11);
        #20;
        check_both("all_ones", 2'b00);
        drive(2'b00);
        #20;
        check_both("all_zeros", 2'b11);
        drive(2'b01);
        #20;
        check_both("mixed_01", 2'b10);
        drive(2'b10);
        #20;
        check_both("mixed_10", 2'b01);

        drive(ax);
        #1;
        check_both("x_prop", ref_inv(ax));

        for (int i = 0; i < 40; i++) begin
            a     = gate_vec_t'($urandom);
            rst_n = 1'($urandom);
            #($urandom_range(1, 7));
            drive(a);
            #1;
            check_both("random", ref_inv(a));
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mod_74x04_2.md
# mod_74x04_2

Two-channel logic inverter slice modelled on two gates of a 74x04 hex inverter. Each output bit is the logical complement of the matching input bit. The block ships as two interchangeable top-level views:
- `mod_74x04_2`: vector-based.
- `mod_74x04_2_split`: built from two single-gate instances.

It sits in the 74xx discrete-logic library as a leaf cell for board-level glue models.

## Interface
Parameters:
- `N_GATES`, default 2: number of inverter channels. Fixed at 2 for this block; other values are unsupported.

Ports (identical for both views):
- `clk`, input, 1 bit: single clock. Used only when `MOD_74X04_2_REG_EN` is defined.
- `rst_n`, input, 1 bit: reset, asynchronous and active-low. Used only when `MOD_74X04_2_REG_EN` is defined.
- `A`, input, 2 bits: gate inputs. Bit i drives gate i (pin pairs 1A/2A).
- `Y`, output, 2 bits: gate outputs. `Y[i]` = NOT `A[i]` (pins 1Y/2Y).

Positional order is `A`, `Y`, then `clk`, `rst_n`. Two-port positional instantiation `(A, Y)` must remain legal with `clk`/`rst_n` left unconnected in the default build.

## Operation
- Per bit: `Y[i] = ~A[i]`. Channels are fully independent; no cross-coupling.
- Truth table per channel: 0 → 1, 1 → 0.
- Unknown handling: X or Z on `A[i]` yields X on `Y[i]`. This is standard Verilog `~` semantics and must not be masked.
- Both views are functionally identical for every input value.
- `mod_74x04_2_split` must instantiate one `mod_74x04_gate` per bit. It must not use a vector operator across bits.

## Timing
- Default build: purely combinational, zero-delay.
  - `Y` settles in the same simulation time step as an `A` change.
  - `clk` and `rst_n` are ignored.
  - No reset value applies; `Y` tracks `A` at all times.
- With `MOD_74X04_2_REG_EN` defined:
  - `Y` is registered on the `clk` rising edge: `Y <= ~A`, giving 1-cycle latency.
  - `rst_n` low asynchronously forces `Y` = 2'b11, the complement of an all-zero input, regardless of `clk`.
  - Release of `rst_n` takes effect on the next rising edge.
  - Reset asserted mid-operation overrides any pending capture immediately.
  - Simultaneous `A` change and clock edge: the value sampled is the pre-edge `A`.

## Configuration
- Macro: `MOD_74X04_2_REG_EN`.
- Undefined (default):
  - Combinational inverters.
  - No flops are inferred.
  - `clk`/`rst_n` are unused inputs.
- Defined:
  - One flop per channel, placed at the output of each `mod_74x04_gate`.
  - Async active-low reset to 1, giving `Y` = 2'b11.
  - Applies identically to both views.

## Structure
- Shared package `mod_74xx_pkg`:
  - `localparam N_GATES_74X04_2 = 2`.
  - Typedef `gate_vec_t` = `logic [1:0]`.
  - Reset constant `Y_RST_74X04 = 2'b11`.
- Sub-module `mod_74x04_gate`:
  - Ports: 1-bit `a` in, 1-bit `y` out, plus `clk`/`rst_n`.
  - Holds the optional register.
  - Used by `_split`; may also be used by the vector view through a generate loop.
- Both tops live in one file set, with no other dependencies.

## Test plan
1. Vector view, default build: `A` = 2'b11, wait 20 time units → `Y` = 2'b00. Then `A` = 2'b00, wait 20 → `Y` = 2'b11.
2. Split view, default build: same stimulus as scenario 1 → `Y` = 2'b00, then `Y` = 2'b11. `Y` must match the vector view bit-for-bit.
3. Mixed bits, both views: `A` = 2'b01 → `Y` = 2'b10. `A` = 2'b10 → `Y` = 2'b01. Confirms channel independence and bit order.
4. X propagation: `A` = 2'b1x → `Y` = 2'b0x in both views.
5. `MOD_74X04_2_REG_EN`, reset:
   - Hold `rst_n` = 0 with `A` = 2'b11 → `Y` = 2'b11 with no clock edge required.
   - Release `rst_n`; first rising edge → `Y` = 2'b00.
6. `MOD_74X04_2_REG_EN`, latency:
   - Change `A` 2'b00 → 2'b10 between edges → `Y` stays 2'b11 until the next rising edge, then becomes 2'b01.
   - Drop `rst_n` mid-cycle → `Y` = 2'b11 immediately.
